// File: rtl/alu_meta.sv
// Pipelined metadata action ALU for a match-action stage.
// One VLIW metadata action per cycle, LATENCY-deep result pipe.
module alu_meta #(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 25,
  parameter int META_LEN   = 256,
  parameter int LATENCY    = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [META_LEN-1:0]   comp_meta_data_in,
  input  logic                  comp_meta_data_valid_in,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid_in,
  output logic [META_LEN-1:0]   comp_meta_data_out,
  output logic                  comp_meta_data_valid_out,
  output logic [CNT_W-1:0]      discard_cnt,
  output logic                  mismatch_err
);

  logic [3:0] opcode;
  logic [7:0] port;
  logic       discard;
  logic [5:0] ntid;
  logic       fire;
  logic       unused_act;

  assign opcode     = action_in[24:21];
  assign port       = action_in[20:13];
  assign discard    = action_in[12];
  assign ntid       = action_in[10:5];
  assign fire       = action_valid_in & comp_meta_data_valid_in;
  assign unused_act = ^action_in;

  logic [META_LEN-1:0] res;

  always_comb begin
    res = comp_meta_data_in;
    case (opcode)
      4'b1100: begin
        res[31:24]   = port;
        res[255:250] = ntid;
      end
      4'b1101: begin
        res[128]     = discard;
        res[255:250] = ntid;
      end
      4'b1110: begin
        res[31:24]   = comp_meta_data_in[31:24] | port;
        res[255:250] = ntid;
      end
      4'b1111: begin
        res[255:250] = ntid;
      end
      default: res = comp_meta_data_in;
    endcase
  end

  logic [META_LEN-1:0] data_q [LATENCY];
  logic [META_LEN-1:0] data_d [LATENCY];
  logic [LATENCY-1:0]  vld_q;
  logic [LATENCY-1:0]  vld_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                mm_q;
  logic                mm_d;

  // Last stage doubles as the output register and holds between results.
  always_comb begin
    vld_d[0]  = fire;
    data_d[0] = res;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    if (!vld_d[LATENCY-1]) begin
      data_d[LATENCY-1] = data_q[LATENCY-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (vld_d[LATENCY-1] && data_d[LATENCY-1][128] && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    mm_d = mm_q | (action_valid_in ^ comp_meta_data_valid_in);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
      cnt_q <= '0;
      mm_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
      cnt_q <= cnt_d;
      mm_q  <= mm_d;
    end
  end

  assign comp_meta_data_out       = data_q[LATENCY-1];
  assign comp_meta_data_valid_out = vld_q[LATENCY-1];
  assign discard_cnt              = cnt_q;
  assign mismatch_err             = mm_q;

endmodule

// File: doc/alu_meta.md
# alu_meta

Parametrised, fully pipelined action ALU for a Menshen match-action stage. It applies one VLIW metadata action per cycle to the per-packet metadata vector:
- set or OR-merge the destination port;
- set the discard flag;
- set the next-table id.

It replaces the single-outstanding FSM ALU and runs at full throughput, with configurable latency, a drop counter and a handshake-mismatch flag. It sits in the action engine next to the header-field ALUs and feeds the stage's metadata output register.

## Interface
- STAGE_ID, 0, stage index; informational only, no behavioural effect
- ACTION_LEN, 25, action word width; must be ≥ 25
- META_LEN, 256, metadata width; must be 256
- LATENCY, 4, cycles from accepting edge to output valid; legal 1..8
- CNT_W, 32, width of discard_cnt
- Ports:
  - clk  in  1  single clock, all logic on rising edge
  - rst_n  in  1  reset, synchronous, active-low
  - comp_meta_data_in  in  META_LEN  metadata to modify
  - comp_meta_data_valid_in  in  1  metadata valid
  - action_in  in  ACTION_LEN  action word
  - action_valid_in  in  1  action valid
  - comp_meta_data_out  out  META_LEN  modified metadata
  - comp_meta_data_valid_out  out  1  one-cycle pulse per result
  - discard_cnt  out  CNT_W  saturating count of emitted results with bit 128 = 1
  - mismatch_err  out  1  sticky: the two valids differed in some cycle

## Operation
- Accept (fire) = action_valid_in & comp_meta_data_valid_in. No backpressure: a fire is allowed every cycle.
- Action fields:
  - opcode = action_in[24:21]
  - port = action_in[20:13]
  - discard = action_in[12]
  - ntid = action_in[10:5]
- Metadata fields:
  - [255:250] next_table_id
  - [249:129] passed through unchanged
  - [128] discard
  - [31:24] dst_port
  - all other bits are passed through unchanged
- Opcode effects, computed in the fire cycle (result R):
  - 4'b1100 set port: R[31:24]=port; R[255:250]=ntid
  - 4'b1101 discard: R[128]=discard; R[255:250]=ntid
  - 4'b1110 multicast merge: R[31:24]=meta[31:24] | port; R[255:250]=ntid
  - 4'b1111 next-table only: R[255:250]=ntid
  - any other opcode: R=comp_meta_data_in unchanged
- R enters a shift pipeline of LATENCY registers, each carrying a valid bit. Results leave in order, one per fire, and none are lost or duplicated.
- comp_meta_data_out updates only when a valid result emerges. Otherwise it holds the last emitted value.
- discard_cnt increments when an emitted result has bit 128 = 1. It saturates at all-ones and never wraps.
- mismatch_err sets when action_valid_in ≠ comp_meta_data_valid_in. No fire happens in that cycle, and the lone input is dropped. The flag clears only on reset.

## Timing
- Reset (rst_n low at an edge):
  - comp_meta_data_out = 0
  - comp_meta_data_valid_out = 0
  - discard_cnt = 0
  - mismatch_err = 0
  - all pipeline valid bits = 0
- Reset mid-operation flushes every in-flight result; none of them ever appears at the output.
- A fire sampled at edge k makes valid_out high for exactly the cycle following edge k+LATENCY-1, with the data stable in that same cycle. LATENCY=1 therefore means a registered output one cycle after the fire.
- Back-to-back fires produce back-to-back valid_out pulses, spaced identically to the fires.
- discard_cnt is updated at the same edge that raises valid_out for the counted result. It is visible together with that result.
- mismatch_err is visible the cycle after the offending edge.
- If a mismatch and reset occur at the same edge, reset wins.

## Test plan
- Reset values: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0; no valid_out for 10 cycles after release with no fires.
- Set port, LATENCY=4: meta=0, action opcode 1100, port=8'h5A, ntid=6'h2B -> exactly 4 cycles later one valid pulse, out[31:24]=5A, out[255:250]=2B, all other bits 0.
- Streaming: 16 consecutive fires with alternating opcodes 1101 (discard=1) and 1110 (meta[31:24]=8'h01, port=8'h80):
  - 16 consecutive valid pulses, in order;
  - merged results show port 81;
  - discard_cnt=8.
- Mismatch: action_valid_in=1 with comp_meta_data_valid_in=0 -> no output, mismatch_err=1 next cycle and stays high through later normal fires.
- Reset flush: fire 3 results, assert rst_n=0 one cycle later for 1 cycle -> zero valid pulses ever appear; outputs return to 0.
- Saturation: CNT_W=4, 20 discard fires -> discard_cnt stops at 4'hF; opcode 0000 passes meta unchanged bit-exact.
